// File: rtl/pipe_fetch_unit_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction memory bus and IF/ID outputs.
// The master drives the controls and the imem read data; the fetch unit is the slave.
interface pipe_fetch_unit_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic [1:0]       BranchMux;
  logic             IfFlush;
  logic [31:0]      branch_target;
  logic [31:0]      imem_data;
  logic [31:0]      imem_addr;
  logic [31:0]      pc;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [5:0]       opcode;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output stall, BranchMux, IfFlush, branch_target, imem_data,
    input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, opcode,
           fetch_count, flush_count
  );

  modport slave (
    input  stall, BranchMux, IfFlush, branch_target, imem_data,
    output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, opcode,
           fetch_count, flush_count
  );
endinterface

// File: rtl/pipe_fetch_unit.sv
// Instruction fetch with IF/ID register for the 5-stage MIPS pipeline.
// Steers the PC from BranchMux, kills the wrong-path slot on IfFlush, holds on stall.
module pipe_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_fetch_unit_if.slave bus
);

  logic [31:0]      r_pc;
  logic [31:0]      r_if_id_instr;
  logic [31:0]      r_if_id_pc4;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [31:0]      w_pc4;
  logic [31:0]      w_next_pc;

  function automatic logic [31:0] sel_next_pc(
    input logic [1:0]  mux,
    input logic [31:0] pc4,
    input logic [31:0] target,
    input logic [31:0] id_pc4,
    input logic [31:0] id_instr
  );
    logic [31:0] npc;
    case (mux)
      2'd1:    npc = {target[31:2], 2'b00};
      2'd2:    npc = {id_pc4[31:28], id_instr[25:0], 2'b00};
      default: npc = pc4;  // 3 is reserved and behaves as sequential
    endcase
    return npc;
  endfunction

  assign w_pc4     = r_pc + 32'd4;
  assign w_next_pc = sel_next_pc(bus.BranchMux, w_pc4, bus.branch_target,
                                 r_if_id_pc4, r_if_id_instr);

  // IF -> IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc4   <= 32'd0;
      r_if_id_valid <= 1'b0;
      r_fetch_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else if (!bus.stall) begin
      r_pc <= w_next_pc;
      if (bus.IfFlush) begin
        r_if_id_instr <= NOP_INSTR;
        r_if_id_pc4   <= 32'd0;
        r_if_id_valid <= 1'b0;
        r_flush_cnt   <= r_flush_cnt + 1'b1;
      end else begin
        r_if_id_instr <= bus.imem_data;
        r_if_id_pc4   <= w_pc4;
        r_if_id_valid <= 1'b1;
        r_fetch_cnt   <= r_fetch_cnt + 1'b1;
      end
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.if_id_instr = r_if_id_instr;
  assign bus.if_id_pc4   = r_if_id_pc4;
  assign bus.if_id_valid = r_if_id_valid;
  assign bus.opcode      = r_if_id_instr[31:26];
  assign bus.fetch_count = r_fetch_cnt;
  assign bus.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit; a second instance with 2-bit counters checks wrap.
module tb_pipe_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_fetch_unit_if #(.CNT_W(16)) bus  ();
  pipe_fetch_unit_if #(.CNT_W(2))  bus2 ();

  pipe_fetch_unit #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  pipe_fetch_unit #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Address-tagged memory, with a j 0x80 planted at 0x1000_0004.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0800_0020;
    return {8'hA5, a[23:0]};
  endfunction

  assign bus.imem_data      = imem(bus.imem_addr);
  assign bus2.imem_data     = imem(bus2.imem_addr);
  assign bus2.stall         = bus.stall;
  assign bus2.BranchMux     = bus.BranchMux;
  assign bus2.IfFlush       = bus.IfFlush;
  assign bus2.branch_target = bus.branch_target;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] bm, input logic fl, input logic [31:0] bt);
    bus.stall         = s;
    bus.BranchMux     = bm;
    bus.IfFlush       = fl;
    bus.branch_target = bt;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic vld);
    check({tag, ".pc"},    bus.pc, pc);
    check({tag, ".addr"},  bus.imem_addr, pc);
    check({tag, ".instr"}, bus.if_id_instr, instr);
    check({tag, ".pc4"},   bus.if_id_pc4, pc4);
    check({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, vld});
  endtask

  task automatic check_cnt(input string tag, input int fetch, input int flush);
    check({tag, ".fetch"}, {16'd0, bus.fetch_count}, fetch);
    check({tag, ".flush"}, {16'd0, bus.flush_count}, flush);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 32'd0);
    tick();
    tick();
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check_cnt("reset", 0, 0);

    // Sequential fetch
    rst = 1'b0;
    tick();
    check_ifid("seq1", 32'h4, imem(32'h0), 32'h4, 1'b1);
    tick();
    check_ifid("seq2", 32'h8, imem(32'h4), 32'h8, 1'b1);
    tick();
    check_ifid("seq3", 32'hC, imem(32'h8), 32'hC, 1'b1);
    check_cnt("seq3", 3, 0);
    check("seq3.small_fetch", {30'd0, bus2.fetch_count}, 32'd3);
    tick();
    check("seq4.pc", bus.pc, 32'h10);

    // Taken beq with flush
    drive(1'b0, 2'd1, 1'b1, 32'h40);
    tick();
    check_ifid("beq", 32'h40, 32'h0, 32'h0, 1'b0);
    check_cnt("beq", 4, 1);
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    check_ifid("beq_tgt", 32'h44, imem(32'h40), 32'h44, 1'b1);
    check("wrap.small_fetch5", {30'd0, bus2.fetch_count}, 32'd1);

    // Jump: land at 0x1000_0004 to pick up j 0x80
    drive(1'b0, 2'd1, 1'b1, 32'h1000_0004);
    tick();
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    check_ifid("jfetch", 32'h1000_0008, 32'h0800_0020, 32'h1000_0008, 1'b1);
    check("jfetch.opcode", {26'd0, bus.opcode}, 32'd2);
    drive(1'b0, 2'd2, 1'b1, 32'h0);
    tick();
    check_ifid("jump", 32'h1000_0080, 32'h0, 32'h0, 1'b0);
    check_cnt("jump", 6, 3);

    // Stall priority at pc 0x20
    drive(1'b0, 2'd1, 1'b1, 32'h1C);
    tick();
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    check_ifid("pre_stall", 32'h20, imem(32'h1C), 32'h20, 1'b1);
    drive(1'b1, 2'd1, 1'b1, 32'h80);
    tick();
    tick();
    check_ifid("stall", 32'h20, imem(32'h1C), 32'h20, 1'b1);
    check_cnt("stall", 7, 4);
    bus.stall = 1'b0;
    tick();
    check_ifid("unstall", 32'h80, 32'h0, 32'h0, 1'b0);
    check_cnt("unstall", 7, 5);

    // Misaligned branch target, redirect without flush keeps the slot
    drive(1'b0, 2'd1, 1'b0, 32'h43);
    tick();
    check_ifid("misalign", 32'h40, imem(32'h80), 32'h84, 1'b1);

    // PC wrap at 2^32
    drive(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFC);
    tick();
    check("wrap.pc_top", bus.pc, 32'hFFFF_FFFC);
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();
    check_ifid("wrap", 32'h0, imem(32'hFFFF_FFFC), 32'h0, 1'b1);
    check_cnt("wrap", 9, 6);
    check("wrap.small_fetch9", {30'd0, bus2.fetch_count}, 32'd1);
    check("wrap.small_flush6", {30'd0, bus2.flush_count}, 32'd2);

    // Reserved BranchMux=3 is sequential; flush without redirect still advances
    drive(1'b0, 2'd3, 1'b0, 32'h40);
    tick();
    check("bm3.pc", bus.pc, 32'h4);
    drive(1'b0, 2'd0, 1'b1, 32'h0);
    tick();
    check_ifid("flush_only", 32'h8, 32'h0, 32'h0, 1'b0);
    check_cnt("flush_only", 10, 7);

    // Reset during stall with a pending redirect
    drive(1'b1, 2'd1, 1'b1, 32'h40);
    rst = 1'b1;
    tick();
    check_ifid("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    check_cnt("rst_stall", 0, 0);
    check("rst_stall.small_fetch", {30'd0, bus2.fetch_count}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 100000);
    $fatal(1);
  end
endmodule
